cpu_skeleton: RTL and testbench

- Top-level wrapper for the single-cycle 32-bit teaching CPU.
- Derives four clocks from the 50 MHz board clock.
- Instantiates the processor core (instance my_processor), the 32x32 register file (instance my_regfile), the instruction ROM and the data RAM.
- Verification taps the internal hierarchy, so the instance and signal names listed under Behaviour are mandatory.

---
 rtl/cpu_skeleton.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_cpu_skeleton.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_skeleton.sv
// ---------------------------------------------------------------------------
// cpu_skeleton: top-level wrapper for the single-cycle 32-bit teaching CPU.
//
// Ports:
//   clock            in   50 MHz board clock (only clock input)
//   reset            in   asynchronous, active-low reset
//   imem_clock       out  ~clock (exported for compatibility only)
//   dmem_clock       out  ~clock (exported for compatibility only)
//   processor_clock  out  clock / 2, toggles on each posedge clock, 0 in reset
//   regfile_clock    out  identical to processor_clock
//
// Parameters:
//   IMEM_INIT   instruction ROM image name (kept for compatibility)
//   IMEM_DEPTH  instruction words (addressed by PC[11:0])
//   DMEM_DEPTH  data words (addressed by effective address [11:0])
//
// Optional feature (macro OVF_STATUS_EN): signed overflow on add/addi/sub
// writes r30 = 1/2/3 instead of rd. Without the macro results wrap into rd.
// ---------------------------------------------------------------------------

module imem #(
  parameter string IMEM_INIT  = "imem.hex",
  parameter int    IMEM_DEPTH = 4096
) (
  input  logic [11:0] address,
  output logic [31:0] q
);
  logic [31:0] rom [0:IMEM_DEPTH-1];

  assign q = rom[address];
endmodule

module dmem #(
  parameter int DMEM_DEPTH = 4096
) (
  input  logic        clock,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q
);
  logic [31:0] ram [0:DMEM_DEPTH-1];

  // No reset: memory contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (wren) ram[address] <= data;
  end

  assign q = ram[address];
endmodule

module regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_writeReg,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? '0 : regs[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? '0 : regs[ctrl_readRegB];
endmodule

module processor (
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] address_imem,
  input  logic [31:0] q_imem,
  output logic [11:0] address_dmem,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q_dmem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB
);
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRA  = 5'b00101;

  logic [31:0] pc, next_pc, pc_plus1, branch_tgt;
  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm, jt, sum_ab, diff_ab, eff;

  assign opcode = q_imem[31:27];
  assign rd     = q_imem[26:22];
  assign rs     = q_imem[21:17];
  assign rt     = q_imem[16:12];
  assign shamt  = q_imem[11:7];
  assign aluop  = q_imem[6:2];
  assign imm    = {{15{q_imem[16]}}, q_imem[16:0]};
  assign jt     = {5'b0, q_imem[26:0]};

  assign pc_plus1   = pc + 32'd1;
  assign branch_tgt = pc_plus1 + imm;
  assign sum_ab     = data_readRegA + data_readRegB;
  assign diff_ab    = data_readRegA - data_readRegB;
  // eff doubles as the addi result and the lw/sw effective address.
  assign eff        = data_readRegA + imm;

`ifdef OVF_STATUS_EN
  logic ovf_add, ovf_sub, ovf_addi;
  assign ovf_add  = (data_readRegA[31] == data_readRegB[31]) && (sum_ab[31]  != data_readRegA[31]);
  assign ovf_sub  = (data_readRegA[31] != data_readRegB[31]) && (diff_ab[31] != data_readRegA[31]);
  assign ovf_addi = (data_readRegA[31] == imm[31])           && (eff[31]     != data_readRegA[31]);
`endif

  assign address_imem = pc[11:0];
  assign address_dmem = eff[11:0];
  assign data         = data_readRegB;

  // Read-port selection depends only on the instruction word; kept apart
  // from the execute block so no combinational loop through the regfile.
  always_comb begin
    ctrl_readRegA = rs;
    ctrl_readRegB = rt;
    case (opcode)
      OP_SW:          ctrl_readRegB = rd;
      OP_JR:          ctrl_readRegA = rd;
      OP_BNE, OP_BLT: begin
        ctrl_readRegA = rd;
        ctrl_readRegB = rs;
      end
      OP_BEX:         ctrl_readRegA = 5'd30;
      default: ;
    endcase
  end

  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = rd;
    data_writeReg    = '0;
    wren             = 1'b0;
    next_pc          = pc_plus1;
    case (opcode)
      OP_RTYPE: begin
        case (aluop)
          ALU_ADD: begin
            ctrl_writeEnable = 1'b1;
            data_writeReg    = sum_ab;
`ifdef OVF_STATUS_EN
            if (ovf_add) begin
              ctrl_writeReg = 5'd30;
              data_writeReg = 32'd1;
            end
`endif
          end
          ALU_SUB: begin
            ctrl_writeEnable = 1'b1;
            data_writeReg    = diff_ab;
`ifdef OVF_STATUS_EN
            if (ovf_sub) begin
              ctrl_writeReg = 5'd30;
              data_writeReg = 32'd3;
            end
`endif
          end
          ALU_AND: begin
            ctrl_writeEnable = 1'b1;
            data_writeReg    = data_readRegA & data_readRegB;
          end
          ALU_OR: begin
            ctrl_writeEnable = 1'b1;
            data_writeReg    = data_readRegA | data_readRegB;
          end
          ALU_SLL: begin
            ctrl_writeEnable = 1'b1;
            data_writeReg    = data_readRegA << shamt;
          end
          ALU_SRA: begin
            ctrl_writeEnable = 1'b1;
            data_writeReg    = 32'($signed(data_readRegA) >>> shamt);
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        ctrl_writeEnable = 1'b1;
        data_writeReg    = eff;
`ifdef OVF_STATUS_EN
        if (ovf_addi) begin
          ctrl_writeReg = 5'd30;
          data_writeReg = 32'd2;
        end
`endif
      end
      OP_SW: wren = 1'b1;
      OP_LW: begin
        ctrl_writeEnable = 1'b1;
        data_writeReg    = q_dmem;
      end
      OP_J:  next_pc = jt;
      OP_JAL: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd31;
        data_writeReg    = pc_plus1;
        next_pc          = jt;
      end
      OP_JR: next_pc = data_readRegA;
      OP_BNE: begin
        if (data_readRegA != data_readRegB) next_pc = branch_tgt;
      end
      OP_BLT: begin
        if ($signed(data_readRegA) < $signed(data_readRegB)) next_pc = branch_tgt;
      end
      OP_SETX: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd30;
        data_writeReg    = jt;
      end
      OP_BEX: begin
        if (data_readRegA != 32'd0) next_pc = jt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= next_pc;
  end
endmodule

module cpu_skeleton #(
  parameter string IMEM_INIT  = "imem.hex",
  parameter int    IMEM_DEPTH = 4096,
  parameter int    DMEM_DEPTH = 4096
) (
  input  logic clock,
  input  logic reset,
  output logic imem_clock,
  output logic dmem_clock,
  output logic processor_clock,
  output logic regfile_clock
);
  logic        div_q;
  logic [11:0] address_imem, address_dmem;
  logic [31:0] q_imem, q_dmem, data;
  logic        wren;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) div_q <= 1'b0;
    else        div_q <= ~div_q;
  end

  assign imem_clock      = ~clock;
  assign dmem_clock      = ~clock;
  assign processor_clock = div_q;
  assign regfile_clock   = div_q;

  processor my_processor (
    .clock            (processor_clock),
    .reset            (reset),
    .address_imem     (address_imem),
    .q_imem           (q_imem),
    .address_dmem     (address_dmem),
    .data             (data),
    .wren             (wren),
    .q_dmem           (q_dmem),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  regfile my_regfile (
    .clock            (regfile_clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  imem #(.IMEM_INIT(IMEM_INIT), .IMEM_DEPTH(IMEM_DEPTH)) my_imem (
    .address (address_imem),
    .q       (q_imem)
  );

  dmem #(.DMEM_DEPTH(DMEM_DEPTH)) my_dmem (
    .clock   (processor_clock),
    .address (address_dmem),
    .data    (data),
    .wren    (wren),
    .q       (q_dmem)
  );
endmodule

// File: tb/tb_cpu_skeleton.sv
// Directed bench for cpu_skeleton: loads a small program into the ROM,
// steps processor_clock edges and checks PC, registers and data memory.
module tb_cpu_skeleton;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic imem_clock, dmem_clock, processor_clock, regfile_clock;

    int  checks   = 0;
    int  failures = 0;
    time t_prev, t_now;

    cpu_skeleton #(.IMEM_INIT(""), .IMEM_DEPTH(4096), .DMEM_DEPTH(4096)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_clock      (imem_clock),
        .dmem_clock      (dmem_clock),
        .processor_clock (processor_clock),
        .regfile_clock   (regfile_clock)
    );

    always #10 clock = ~clock;

    function automatic logic [31:0] enc_r(input logic [4:0] aluop, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] shamt);
        return {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input int n);
        logic [31:0] nv;
        nv = n;
        return {op, rd, rs, nv[16:0]};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input int t);
        logic [31:0] tv;
        tv = t;
        return {op, tv[26:0]};
    endfunction

    task automatic load(input logic [11:0] a, input logic [31:0] w);
        dut.my_imem.rom[a] = w;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        check32(tag, dut.my_regfile.regs[r], exp);
    endtask

    // Advance to the next rising edge of processor_clock (bounded), then
    // check the PC that edge produced.
    task automatic step(input logic [11:0] exp_pc, input string tag);
        bit seen_low, seen_high;
        seen_low  = (processor_clock === 1'b0);
        seen_high = 1'b0;
        for (int i = 0; i < 6 && !seen_high; i++) begin
            @(posedge clock);
            #1;
            if (processor_clock === 1'b0) seen_low = 1'b1;
            else if (seen_low)            seen_high = 1'b1;
        end
        t_prev = t_now;
        t_now  = $time;
        check32({tag, "_pclk_edge"}, {31'b0, seen_high}, 32'd1);
        check32(tag, {20'b0, dut.my_processor.address_imem}, {20'b0, exp_pc});
    endtask

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3, SLL = 5'd4, SRA = 5'd5;
    localparam logic [4:0] J = 5'b00001, BNE = 5'b00010, JAL = 5'b00011, JR = 5'b00100;
    localparam logic [4:0] ADDI = 5'b00101, BLT = 5'b00110, SW = 5'b00111, LW = 5'b01000;
    localparam logic [4:0] SETX = 5'b10101, BEX = 5'b10110;

    initial begin
        logic [31:0] acc;
        for (int i = 0; i < 4096; i++) load(12'(i), 32'd0);
        load(0,  enc_i(ADDI, 1, 0, 5));
        load(1,  enc_i(ADDI, 2, 0, 7));
        load(2,  enc_r(ADD, 3, 1, 2, 0));
        load(3,  enc_j(JAL, 10));
        load(4,  enc_i(BNE, 1, 2, 2));
        load(5,  enc_i(ADDI, 20, 0, 1));
        load(6,  enc_i(ADDI, 20, 0, 1));
        load(7,  enc_i(BLT, 2, 1, 2));
        load(8,  enc_i(BNE, 0, 0, -1));
        load(9,  enc_j(J, 11));
        load(10, enc_i(JR, 31, 0, 0));
        load(11, enc_r(SUB, 4, 1, 2, 0));
        load(12, enc_j(BEX, 20));
        load(13, enc_j(SETX, 5));
        load(14, enc_j(BEX, 24));
        load(24, enc_i(SW, 3, 0, 4));
        load(25, enc_i(LW, 5, 0, 4));
        load(26, enc_r(SLL, 6, 1, 0, 3));
        load(27, enc_i(ADDI, 7, 0, -16));
        load(28, enc_r(SRA, 8, 7, 0, 2));
        load(29, enc_r(AND_, 9, 1, 2, 0));
        load(30, enc_r(OR_, 10, 1, 2, 0));
        load(31, enc_i(ADDI, 0, 0, 9));
        load(32, enc_i(ADDI, 11, 0, 1));
        load(33, enc_r(SLL, 11, 11, 0, 31));
        load(34, enc_i(ADDI, 12, 0, -1));
        load(35, enc_r(ADD, 13, 11, 12, 0));
        load(36, 32'hF800_0000);
        load(37, enc_i(BLT, 1, 2, -1));

        repeat (4) @(posedge clock);
        #1;
        check32("imem_clock_hi_phase", {31'b0, imem_clock}, {31'b0, ~clock});
        check32("dmem_clock_hi_phase", {31'b0, dmem_clock}, {31'b0, ~clock});
        repeat (4) @(posedge clock);
        @(negedge clock);
        #1;
        check32("imem_clock_lo_phase", {31'b0, imem_clock}, {31'b0, ~clock});
        check32("reset_pc", {20'b0, dut.my_processor.address_imem}, 32'd0);
        check32("reset_pclk", {30'b0, regfile_clock, processor_clock}, 32'd0);
        acc = '0;
        for (int i = 0; i < 32; i++) acc = acc | dut.my_regfile.regs[i];
        check32("reset_regs_zero", acc, 32'd0);
        check32("reset_fetch_word", dut.my_processor.q_imem, 32'h2840_0005);

        reset = 1'b1;
        step(1, "pc_after_0");
        step(2, "pc_after_1");
        check32("pclk_period_ns", 32'(t_now - t_prev), 32'd40);
        chk_reg("addi_r1", 1, 32'd5);
        chk_reg("addi_r2", 2, 32'd7);
        step(3,  "pc_after_2");
        chk_reg("add_r3", 3, 32'd12);
        step(10, "jal_target");
        chk_reg("jal_r31", 31, 32'd4);
        step(4,  "jr_target");
        step(7,  "bne_taken");
        step(8,  "blt_not_taken");
        step(9,  "bne_self_fallthrough");
        step(11, "j_target");
        step(12, "pc_after_sub");
        chk_reg("sub_r4", 4, 32'hFFFF_FFFE);
        step(13, "bex_not_taken");
        step(14, "pc_after_setx");
        chk_reg("setx_r30", 30, 32'd5);
        step(24, "bex_taken");
        step(25, "pc_after_sw");
        check32("sw_mem4", dut.my_dmem.ram[4], 32'd12);
        step(26, "pc_after_lw");
        chk_reg("lw_r5", 5, 32'd12);
        for (int p = 27; p <= 37; p++) step(12'(p), "seq_pc");
        step(37, "blt_self_loop");
        step(37, "blt_self_loop2");

        chk_reg("skipped_r20", 20, 32'd0);
        chk_reg("sll_r6", 6, 32'd40);
        chk_reg("addi_neg_r7", 7, 32'hFFFF_FFF0);
        chk_reg("sra_r8", 8, 32'hFFFF_FFFC);
        chk_reg("and_r9", 9, 32'd5);
        chk_reg("or_r10", 10, 32'd7);
        chk_reg("r0_ignored", 0, 32'd0);
        check32("r0_read_port", (dut.my_regfile.ctrl_readRegA == 5'd0) ? dut.my_regfile.data_readRegA : 32'd0, 32'd0);
        chk_reg("sll31_r11", 11, 32'h8000_0000);
        chk_reg("addi_m1_r12", 12, 32'hFFFF_FFFF);
`ifdef OVF_STATUS_EN
        chk_reg("ovf_add_rd_kept", 13, 32'd0);
        chk_reg("ovf_add_r30", 30, 32'd1);
`else
        chk_reg("wrap_add_r13", 13, 32'h7FFF_FFFF);
        chk_reg("wrap_add_r30", 30, 32'd5);
`endif
        chk_reg("jal_r31_final", 31, 32'd4);

        // Asynchronous reset mid-cycle: state clears at once, data memory kept.
        @(negedge clock);
        #3;
        reset = 1'b0;
        #1;
        check32("async_reset_pc", {20'b0, dut.my_processor.address_imem}, 32'd0);
        check32("async_reset_pclk", {31'b0, processor_clock}, 32'd0);
        chk_reg("async_reset_r1", 1, 32'd0);
        chk_reg("async_reset_r31", 31, 32'd0);
        check32("async_reset_mem4_kept", dut.my_dmem.ram[4], 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
